pc_fetch_unit: RTL and testbench

Holds the architectural program counter and runs the instruction-fetch handshake with instruction memory. Sits directly downstream of the next-PC computation: it consumes the 64-bit NextPC that logic produces and feeds CurrentPC back to it. It also presents a registered instruction plus valid flag to decode. Decode may stall it, and it traps on a misaligned next PC.

---
 rtl/pc_fetch_unit_if.sv | 23 ++
 rtl/pc_fetch_unit.sv | 97 +++++++++
 tb/tb_pc_fetch_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between the PC fetch unit and instruction memory.
interface pc_fetch_unit_if;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;

  // The fetch unit issues requests and receives data.
  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemData
  );

  // Instruction memory answers requests.
  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemData
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Architectural PC holder and instruction-fetch handshake. Fetches the word at
// CurrentPC, presents it to decode until decode accepts it, then takes NextPC
// verbatim. A misaligned NextPC parks the unit in a terminal fault state.
module pc_fetch_unit #(
  parameter logic [63:0] START_PC = 64'h0
) (
  input  logic                   CLK,
  input  logic                   Reset_L,
  input  logic [63:0]            NextPC,
  input  logic                   Stall,
  pc_fetch_unit_if.master        imem,
  output logic [63:0]            CurrentPC,
  output logic [31:0]            Instruction,
  output logic                   InstrValid,
  output logic [31:0]            InstrCount,
  output logic                   MisalignFault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        fault_q, fault_d;

  // State and datapath registers; reset returns everything to the IDLE values.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      instr_q <= 32'h0;
      count_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: capture on ack in FETCH, advance or trap in HOLD.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        // IMemReq is high throughout FETCH, so ack alone qualifies the data.
        if (imem.IMemAck) begin
          instr_d = imem.IMemData;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!Stall) begin
          pc_d    = NextPC;
          count_d = count_q + 32'd1;
          if (NextPC[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come from registers or a decode of the state register only.
  assign imem.IMemReq  = (state_q == FETCH);
  assign imem.IMemAddr = pc_q;
  assign CurrentPC     = pc_q;
  assign Instruction   = instr_q;
  assign InstrValid    = (state_q == HOLD);
  assign InstrCount    = count_q;
  assign MisalignFault = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a scoreboard of expected fetch
// addresses and captured instructions.
module tb_pc_fetch_unit;

  localparam logic [63:0] START = 64'h100;

  logic        CLK;
  logic        Reset_L;
  logic [63:0] NextPC;
  logic        Stall;
  logic [63:0] CurrentPC;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [31:0] InstrCount;
  logic        MisalignFault;

  pc_fetch_unit_if imem ();

  pc_fetch_unit #(.START_PC(START)) dut (
    .CLK          (CLK),
    .Reset_L      (Reset_L),
    .NextPC       (NextPC),
    .Stall        (Stall),
    .imem         (imem),
    .CurrentPC    (CurrentPC),
    .Instruction  (Instruction),
    .InstrValid   (InstrValid),
    .InstrCount   (InstrCount),
    .MisalignFault(MisalignFault)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_addr[$];
  logic [31:0] exp_instr[$];
  logic        prev_req = 1'b0;
  logic        prev_vld = 1'b0;
  logic [63:0] model_pc;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, and retire scoreboard entries
  // on a new fetch request or a newly valid instruction.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (imem.IMemReq === 1'b1 && prev_req !== 1'b1) begin
      checks++;
      assert (exp_addr.size() != 0) else begin
        errors++;
        $error("FAIL sb_addr_empty: observed fetch of %h expected no fetch", imem.IMemAddr);
      end
      if (exp_addr.size() != 0) chk("sb_addr", imem.IMemAddr, exp_addr.pop_front());
    end
    if (InstrValid === 1'b1 && prev_vld !== 1'b1) begin
      checks++;
      assert (exp_instr.size() != 0) else begin
        errors++;
        $error("FAIL sb_instr_empty: observed instruction %h expected none", Instruction);
      end
      if (exp_instr.size() != 0) chk("sb_instr", {32'h0, Instruction}, {32'h0, exp_instr.pop_front()});
    end
    prev_req = imem.IMemReq;
    prev_vld = InstrValid;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"},   {63'h0, imem.IMemReq}, 64'h0);
    chk({tag, "_pc"},    CurrentPC, START);
    chk({tag, "_vld"},   {63'h0, InstrValid}, 64'h0);
    chk({tag, "_instr"}, {32'h0, Instruction}, 64'h0);
    chk({tag, "_cnt"},   {32'h0, InstrCount}, 64'h0);
    chk({tag, "_fault"}, {63'h0, MisalignFault}, 64'h0);
  endtask

  // Release reset between edges and run the zero-wait startup sequence.
  task automatic startup(input string tag);
    Reset_L = 1'b1;
    imem.IMemAck  = 1'b1;
    imem.IMemData = 32'h8B020020;
    exp_addr.push_back(START);
    exp_instr.push_back(32'h8B020020);
    tick();
    chk({tag, "_e1_req"},  {63'h0, imem.IMemReq}, 64'h1);
    chk({tag, "_e1_addr"}, imem.IMemAddr, START);
    chk({tag, "_e1_vld"},  {63'h0, InstrValid}, 64'h0);
    tick();
    chk({tag, "_e2_vld"},   {63'h0, InstrValid}, 64'h1);
    chk({tag, "_e2_instr"}, {32'h0, Instruction}, 64'h8B020020);
    chk({tag, "_e2_pc"},    CurrentPC, START);
    chk({tag, "_e2_req"},   {63'h0, imem.IMemReq}, 64'h0);
    model_pc = START;
  endtask

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no completion expected finish before limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    Reset_L       = 1'b1;
    NextPC        = 64'h0;
    Stall         = 1'b0;
    imem.IMemAck  = 1'b0;
    imem.IMemData = 32'h0;
    #1 Reset_L = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_values("rst");

    startup("start");

    // Sequential fetch, zero-wait memory, five advances.
    for (int i = 0; i < 5; i++) begin
      NextPC = model_pc + 64'd4;
      Stall  = 1'b0;
      exp_addr.push_back(model_pc + 64'd4);
      model_pc = model_pc + 64'd4;
      imem.IMemData = 32'hA000_0000 + 32'(i);
      exp_instr.push_back(32'hA000_0000 + 32'(i));
      tick();
      chk("seq_vld_lo", {63'h0, InstrValid}, 64'h0);
      tick();
      chk("seq_vld_hi", {63'h0, InstrValid}, 64'h1);
    end
    chk("seq_count", {32'h0, InstrCount}, 64'd5);
    chk("seq_pc", CurrentPC, 64'h114);

    // Wait states: three cycles without ack, bogus data on the bus.
    NextPC = 64'h118;
    exp_addr.push_back(64'h118);
    tick();
    imem.IMemAck  = 1'b0;
    imem.IMemData = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req",  {63'h0, imem.IMemReq}, 64'h1);
      chk("wait_addr", imem.IMemAddr, 64'h118);
      chk("wait_vld",  {63'h0, InstrValid}, 64'h0);
    end
    imem.IMemAck  = 1'b1;
    imem.IMemData = 32'h12345678;
    exp_instr.push_back(32'h12345678);
    tick();
    chk("wait_vld_after_ack", {63'h0, InstrValid}, 64'h1);
    chk("wait_count", {32'h0, InstrCount}, 64'd6);

    // Stall with a wandering NextPC (including misaligned values), then branch.
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      NextPC = 64'h200 + 64'(i * 3);
      tick();
      chk("stall_instr", {32'h0, Instruction}, 64'h12345678);
      chk("stall_pc",    CurrentPC, 64'h118);
      chk("stall_cnt",   {32'h0, InstrCount}, 64'd6);
      chk("stall_vld",   {63'h0, InstrValid}, 64'h1);
    end
    Stall  = 1'b0;
    NextPC = 64'h40;
    exp_addr.push_back(64'h40);
    imem.IMemData = 32'hAAAA5555;
    exp_instr.push_back(32'hAAAA5555);
    tick();
    chk("branch_addr", imem.IMemAddr, 64'h40);
    chk("branch_cnt",  {32'h0, InstrCount}, 64'd7);
    tick();

    // Misaligned next PC traps permanently.
    NextPC = 64'h106;
    tick();
    chk("mis_fault", {63'h0, MisalignFault}, 64'h1);
    chk("mis_pc",    CurrentPC, 64'h106);
    chk("mis_cnt",   {32'h0, InstrCount}, 64'd8);
    NextPC = 64'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fault_req",   {63'h0, imem.IMemReq}, 64'h0);
      chk("fault_vld",   {63'h0, InstrValid}, 64'h0);
      chk("fault_pc",    CurrentPC, 64'h106);
      chk("fault_stick", {63'h0, MisalignFault}, 64'h1);
    end
    Reset_L = 1'b0;
    #1;
    chk_reset_values("fault_rst");
    prev_req = imem.IMemReq;
    prev_vld = InstrValid;

    // Async reset while waiting on memory in FETCH.
    Reset_L = 1'b1;
    imem.IMemAck = 1'b0;
    exp_addr.push_back(START);
    tick();
    tick();
    chk("mid_req_before", {63'h0, imem.IMemReq}, 64'h1);
    #1 Reset_L = 1'b0;
    #1;
    chk_reset_values("mid_rst");
    prev_req = imem.IMemReq;
    prev_vld = InstrValid;
    @(posedge CLK);
    #1;
    chk("mid_rst_hold_req", {63'h0, imem.IMemReq}, 64'h0);
    startup("restart");

    // NextPC is taken verbatim, including a 64-bit wrap to zero.
    NextPC = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_addr.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    imem.IMemData = 32'h0BAD_F00D;
    exp_instr.push_back(32'h0BAD_F00D);
    tick();
    tick();
    NextPC = 64'h0;
    exp_addr.push_back(64'h0);
    tick();
    chk("wrap_addr", imem.IMemAddr, 64'h0);
    chk("wrap_cnt",  {32'h0, InstrCount}, 64'd2);
    chk("wrap_fault", {63'h0, MisalignFault}, 64'h0);

    chk("sb_addr_drained",  64'(exp_addr.size()), 64'h0);
    chk("sb_instr_drained", 64'(exp_instr.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
